// File: rtl/cmt_pkg.sv
// Shared definitions for the layered-circuit proof scheduler.
package cmt_pkg;

    localparam int DEF_UINT_WIDTH = 32;
    localparam int DEF_NUM_LAYERS = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_QUERY,
        S_LAUNCH,
        S_WAIT,
        S_FINAL,
        S_DONE
    } state_t;

endpackage

// File: rtl/cmt_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear, flags the TIMEOUT-th one.
module cmt_watchdog #(
    parameter  int TIMEOUT = 1024,
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_eff;

    // clr takes effect in the same cycle, so the first cycle of a new state counts as cycle 1
    assign cnt_eff = clr ? '0 : cnt;
    assign expired = en && (cnt_eff == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (en)
            cnt <= cnt_eff + 1'b1;
        else
            cnt <= '0;
    end

endmodule

// File: rtl/cmt_layer_scheduler.sv
// Verifier-side scheduler for a layered-circuit proof: seeds a gate label, then walks
// one sum-check per layer and compares the last reduced claim with the prover's input value.
module cmt_layer_scheduler
    import cmt_pkg::*;
#(
    parameter  int UINT_WIDTH = DEF_UINT_WIDTH,
    parameter  int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter  int TIMEOUT    = 1024,
    localparam int NUM_BITS   = NUM_LAYERS - 1,
    localparam int LW         = $clog2(NUM_LAYERS) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  random,
    output logic                  qry_req,
    output logic                  qry_final,
    input  logic                  qry_ack,
    input  logic [UINT_WIDTH-1:0] qry_data,
    output logic                  sc_start,
    output logic [UINT_WIDTH-1:0] sc_claim,
    input  logic                  sc_done,
    input  logic                  sc_accept,
    input  logic [UINT_WIDTH-1:0] sc_reduced,
    output logic [LW-1:0]         layer,
    output logic [NUM_BITS-1:0]   gate_lbl,
    output logic                  busy,
    output logic                  done,
    output logic                  accept
);

    state_t                state;
    logic [UINT_WIDTH-1:0] claim;
    logic [LW-1:0]         seed_cnt;
    logic [LW-1:0]         layer_nxt;
    logic                  wd_clr;
    logic                  wd_en;
    logic                  wd_expired;

    assign wd_en     = (state == S_QUERY) || (state == S_WAIT) || (state == S_FINAL);
    assign layer_nxt = layer + LW'(1);

    cmt_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            claim     <= '0;
            seed_cnt  <= '0;
            wd_clr    <= 1'b0;
            layer     <= '0;
            gate_lbl  <= '0;
            accept    <= 1'b1;
            done      <= 1'b0;
            busy      <= 1'b0;
            qry_req   <= 1'b0;
            qry_final <= 1'b0;
            sc_start  <= 1'b0;
            sc_claim  <= '0;
        end else begin
            // wd_clr pulses for the first cycle of every new state
            wd_clr   <= 1'b0;
            sc_start <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_SEED;
                        wd_clr   <= 1'b1;
                        layer    <= '0;
                        gate_lbl <= '0;
                        seed_cnt <= '0;
                        accept   <= 1'b1;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_SEED: begin
                    gate_lbl <= NUM_BITS'({gate_lbl, random});
                    seed_cnt <= seed_cnt + LW'(1);
                    if (seed_cnt == LW'(NUM_BITS - 1)) begin
                        state     <= S_QUERY;
                        wd_clr    <= 1'b1;
                        qry_req   <= 1'b1;
                        qry_final <= 1'b0;
                    end
                end
                S_QUERY: begin
                    if (qry_ack) begin
                        claim    <= qry_data;
                        qry_req  <= 1'b0;
                        sc_start <= 1'b1;
                        sc_claim <= qry_data;
                        state    <= S_LAUNCH;
                        wd_clr   <= 1'b1;
                    end else if (wd_expired) begin
                        qry_req <= 1'b0;
                        accept  <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_DONE;
                        wd_clr  <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    state  <= S_WAIT;
                    wd_clr <= 1'b1;
                end
                S_WAIT: begin
                    if (sc_done && !sc_accept) begin
                        accept <= 1'b0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_DONE;
                        wd_clr <= 1'b1;
                    end else if (sc_done) begin
                        claim  <= sc_reduced;
                        layer  <= layer_nxt;
                        wd_clr <= 1'b1;
                        if (layer_nxt == LW'(NUM_LAYERS - 1)) begin
                            qry_req   <= 1'b1;
                            qry_final <= 1'b1;
                            state     <= S_FINAL;
                        end else begin
                            sc_start <= 1'b1;
                            sc_claim <= sc_reduced;
                            state    <= S_LAUNCH;
                        end
                    end else if (wd_expired) begin
                        accept <= 1'b0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_DONE;
                        wd_clr <= 1'b1;
                    end
                end
                S_FINAL: begin
                    if (qry_ack || wd_expired) begin
                        accept    <= qry_ack && (qry_data == claim);
                        qry_req   <= 1'b0;
                        qry_final <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_DONE;
                        wd_clr    <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmt_layer_scheduler.sv
// Scoreboard bench: stimulus pushes expected launches/verdicts, a negedge monitor pops and compares.
module tb_cmt_layer_scheduler;

    localparam int UW = 32;
    localparam int NL = 4;
    localparam int TO = 16;
    localparam int NB = NL - 1;
    localparam int LW = $clog2(NL) + 1;

    logic          clk, rst, start, random;
    logic          qry_req, qry_final, qry_ack;
    logic [UW-1:0] qry_data;
    logic          sc_start, sc_done, sc_accept;
    logic [UW-1:0] sc_claim, sc_reduced;
    logic [LW-1:0] layer;
    logic [NB-1:0] gate_lbl;
    logic          busy, done, accept;

    cmt_layer_scheduler #(.UINT_WIDTH(UW), .NUM_LAYERS(NL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .random(random),
        .qry_req(qry_req), .qry_final(qry_final), .qry_ack(qry_ack), .qry_data(qry_data),
        .sc_start(sc_start), .sc_claim(sc_claim), .sc_done(sc_done), .sc_accept(sc_accept),
        .sc_reduced(sc_reduced), .layer(layer), .gate_lbl(gate_lbl),
        .busy(busy), .done(done), .accept(accept)
    );

    // kind 0 = sum-check launch, kind 1 = final verdict; cyc < 0 means timing not checked
    typedef struct {
        int            kind;
        logic [UW-1:0] claim;
        logic          acc;
        logic [LW-1:0] layer;
        logic [NB-1:0] lbl;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    logic done_d  = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    endtask

    task automatic fail_event(input string name);
        n_total++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    task automatic push_launch(input logic [UW-1:0] c);
        exp_t x;
        x.kind = 0; x.claim = c; x.acc = 1'b0; x.layer = '0; x.lbl = '0; x.cyc = -1;
        exp_q.push_back(x);
    endtask

    task automatic push_done(input logic a, input logic [LW-1:0] l, input logic [NB-1:0] g, input int c);
        exp_t x;
        x.kind = 1; x.claim = '0; x.acc = a; x.layer = l; x.lbl = g; x.cyc = c;
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sc_start) begin
                if (exp_q.size() == 0) fail_event("unexpected_launch");
                else begin
                    e = exp_q.pop_front();
                    check("launch_kind", 64'(e.kind), 64'd0);
                    if (e.kind == 0) check("sc_claim", 64'(sc_claim), 64'(e.claim));
                end
            end
            if (done && !done_d) begin
                if (exp_q.size() == 0) fail_event("unexpected_done");
                else begin
                    e = exp_q.pop_front();
                    check("done_kind", 64'(e.kind), 64'd1);
                    if (e.kind == 1) begin
                        check("accept", 64'(accept), 64'(e.acc));
                        check("layer", 64'(layer), 64'(e.layer));
                        check("gate_lbl", 64'(gate_lbl), 64'(e.lbl));
                        if (e.cyc >= 0) check("done_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
            end
        end
        done_d <= done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic [NB-1:0] bits);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = NB - 1; i >= 0; i--) begin
            random = bits[i];
            tick();
        end
        random = 1'b0;
    endtask

    task automatic wait_qry(input logic fin);
        int n = 0;
        while (!(qry_req && qry_final == fin) && n < 200) begin
            tick();
            n++;
        end
        if (n == 200) fail_event("qry_req_wait");
    endtask

    task automatic query(input logic fin, input logic [UW-1:0] d);
        wait_qry(fin);
        qry_ack  = 1'b1;
        qry_data = d;
        tick();
        qry_ack  = 1'b0;
    endtask

    task automatic wait_sc();
        int n = 0;
        while (!sc_start && n < 200) begin
            tick();
            n++;
        end
        if (n == 200) fail_event("sc_start_wait");
    endtask

    task automatic sc_round(input logic acc, input logic [UW-1:0] red);
        wait_sc();
        tick();
        sc_done    = 1'b1;
        sc_accept  = acc;
        sc_reduced = red;
        tick();
        sc_done    = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        if (n == 200) fail_event("done_wait");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_accept"}, 64'(accept), 64'd1);
        check({tag, "_layer"}, 64'(layer), 64'd0);
        check({tag, "_gate_lbl"}, 64'(gate_lbl), 64'd0);
        check({tag, "_qry_req"}, 64'(qry_req), 64'd0);
        check({tag, "_qry_final"}, 64'(qry_final), 64'd0);
        check({tag, "_sc_start"}, 64'(sc_start), 64'd0);
        check({tag, "_sc_claim"}, 64'(sc_claim), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int q0;
        rst = 1'b1; start = 1'b0; random = 1'b0; qry_ack = 1'b0; qry_data = '0;
        sc_done = 1'b0; sc_accept = 1'b0; sc_reduced = '0;
        tick();
        tick();
        check_reset_outputs("rst0");
        rst = 1'b0;
        tick();

        // honest run: bits 1,0,1; claims 7 -> 9 -> 11 -> 13; final value matches
        push_launch(7); push_launch(9); push_launch(11);
        push_done(1'b1, 3, 3'b101, -1);
        begin_run(3'b101);
        query(1'b0, 7);
        sc_round(1'b1, 9);
        sc_round(1'b1, 11);
        sc_round(1'b1, 13);
        query(1'b1, 13);
        wait_done();

        // stray sc_done in LAUNCH and start in WAIT are ignored; second sum-check rejects
        push_launch(7); push_launch(9);
        push_done(1'b0, 1, 3'b101, -1);
        begin_run(3'b101);
        query(1'b0, 7);
        wait_sc();
        sc_done = 1'b1; sc_accept = 1'b0; sc_reduced = 32'hdead;
        tick();
        sc_done = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        sc_done = 1'b1; sc_accept = 1'b1; sc_reduced = 9;
        tick();
        sc_done = 1'b0;
        sc_round(1'b0, 99);
        wait_done();

        // final value 14 against reduced claim 13 is rejected
        push_launch(7); push_launch(9); push_launch(11);
        push_done(1'b0, 3, 3'b011, -1);
        begin_run(3'b011);
        query(1'b0, 7);
        sc_round(1'b1, 9);
        sc_round(1'b1, 11);
        sc_round(1'b1, 13);
        query(1'b1, 14);
        wait_done();

        // no qry_ack: verdict lands exactly TO cycles after entering QUERY
        begin_run(3'b110);
        q0 = cyc;
        push_done(1'b0, 0, 3'b110, q0 + TO);
        wait_done();

        // ack in the TO-th QUERY cycle beats the watchdog
        begin_run(3'b001);
        push_launch(5);
        repeat (TO - 1) tick();
        qry_ack = 1'b1; qry_data = 5;
        tick();
        qry_ack = 1'b0;
        check("ack_wins_accept", 64'(accept), 64'd1);
        check("ack_wins_busy", 64'(busy), 64'd1);
        push_launch(6);
        sc_round(1'b1, 6);
        wait_sc();
        tick();
        check("layer_before_rst", 64'(layer), 64'd1);

        // reset in WAIT of the second layer; later sc_done/qry_ack have no effect
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("rst_wait");
        sc_done = 1'b1; sc_accept = 1'b0; qry_ack = 1'b1; qry_data = 1;
        repeat (3) tick();
        sc_done = 1'b0; qry_ack = 1'b0;
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_done", 64'(done), 64'd0);
        check("post_rst_accept", 64'(accept), 64'd1);
        check("post_rst_layer", 64'(layer), 64'd0);

        repeat (3) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
